spwm_deadtime_generator: RTL and testbench

SPWM_DEADTIME_GENERATOR -- requirements
Module: spwm_deadtime_generator

---
 rtl/spwm_deadtime_generator.sv | 156 +++++++++++++++
 tb/tb_spwm_deadtime_generator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spwm_deadtime_generator.sv
// Three-phase sinusoidal PWM: triangle carrier, valley-latched references,
// per-phase complementary gate drive with dead-time insertion and fault trip.
module spwm_deadtime_generator #(
  parameter int CARRIER_MAX = 4095,
  parameter int DEADTIME    = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] modulated_wave_1,
  input  logic [11:0] modulated_wave_2,
  input  logic [11:0] modulated_wave_3,
  input  logic        fault_in,
  input  logic        fault_clear,
  output logic [2:0]  gate_hi,
  output logic [2:0]  gate_lo,
  output logic [11:0] carrier,
  output logic        carrier_valley,
  output logic        fault_latched
);

  localparam logic [11:0] CMAX = 12'(CARRIER_MAX);
  localparam logic [7:0]  DT   = 8'(DEADTIME);

  typedef enum logic [1:0] {LO_ON, DEAD, HI_ON} state_e;

  logic [11:0]       carrier_q, carrier_d;
  logic              dir_up_q, dir_up_d;
  logic              valley_q, valley_d;
  logic              fault_q, fault_d;
  logic [2:0][11:0]  shadow_q, shadow_d;
  logic [2:0][11:0]  refs;
  logic [2:0]        cmp_q, cmp_d;
  logic [2:0]        tgt_hi_q, tgt_hi_d;
  logic [2:0][7:0]   cnt_q, cnt_d;
  state_e            state_q [3];
  state_e            state_d [3];
  logic [2:0]        gate_hi_q, gate_hi_d;
  logic [2:0]        gate_lo_q, gate_lo_d;
  logic              run, force_dead;

  assign refs = {modulated_wave_3, modulated_wave_2, modulated_wave_1};

  always_comb begin
    carrier_d  = carrier_q;
    dir_up_d   = dir_up_q;
    shadow_d   = shadow_q;
    tgt_hi_d   = tgt_hi_q;
    cnt_d      = cnt_q;
    gate_hi_d  = '0;
    gate_lo_d  = '0;
    cmp_d      = '0;
    for (int n = 0; n < 3; n++) state_d[n] = state_q[n];

    run        = enable & ~fault_q;
    fault_d    = fault_in | (fault_q & ~fault_clear);
    force_dead = ~run | fault_in;
    valley_d   = run && (carrier_q == 12'd0);

    if (!run) begin
      carrier_d = 12'd0;
      dir_up_d  = 1'b1;
    end else if (dir_up_q) begin
      if (carrier_q == CMAX) begin
        carrier_d = CMAX - 12'd1;
        dir_up_d  = 1'b0;
      end else begin
        carrier_d = carrier_q + 12'd1;
      end
    end else begin
      if (carrier_q == 12'd0) begin
        carrier_d = 12'd1;
        dir_up_d  = 1'b1;
      end else begin
        carrier_d = carrier_q - 12'd1;
      end
    end

    for (int n = 0; n < 3; n++) begin
      if (valley_d) shadow_d[n] = (refs[n] > CMAX) ? CMAX : refs[n];
      cmp_d[n] = shadow_q[n] > carrier_q;

      if (force_dead) begin
        state_d[n]  = DEAD;
        tgt_hi_d[n] = 1'b0;
        cnt_d[n]    = DT;
      end else begin
        case (state_q[n])
          LO_ON: if (cmp_q[n]) begin
            state_d[n]  = DEAD;
            tgt_hi_d[n] = 1'b1;
            cnt_d[n]    = DT;
          end
          HI_ON: if (!cmp_q[n]) begin
            state_d[n]  = DEAD;
            tgt_hi_d[n] = 1'b0;
            cnt_d[n]    = DT;
          end
          DEAD: begin
            // A demand flip during dead time restarts the full interval.
            if (cmp_q[n] != tgt_hi_q[n]) begin
              tgt_hi_d[n] = cmp_q[n];
              cnt_d[n]    = DT;
            end else if (cnt_q[n] <= 8'd1) begin
              state_d[n] = tgt_hi_q[n] ? HI_ON : LO_ON;
            end else begin
              cnt_d[n] = cnt_q[n] - 8'd1;
            end
          end
          default: begin
            state_d[n]  = DEAD;
            tgt_hi_d[n] = 1'b0;
            cnt_d[n]    = DT;
          end
        endcase
      end
      gate_hi_d[n] = (state_d[n] == HI_ON);
      gate_lo_d[n] = (state_d[n] == LO_ON);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carrier_q <= '0;
      dir_up_q  <= 1'b1;
      valley_q  <= 1'b0;
      fault_q   <= 1'b0;
      shadow_q  <= '0;
      cmp_q     <= '0;
      tgt_hi_q  <= '0;
      cnt_q     <= {3{DT}};
      gate_hi_q <= '0;
      gate_lo_q <= '0;
      for (int n = 0; n < 3; n++) state_q[n] <= DEAD;
    end else begin
      carrier_q <= carrier_d;
      dir_up_q  <= dir_up_d;
      valley_q  <= valley_d;
      fault_q   <= fault_d;
      shadow_q  <= shadow_d;
      cmp_q     <= cmp_d;
      tgt_hi_q  <= tgt_hi_d;
      cnt_q     <= cnt_d;
      gate_hi_q <= gate_hi_d;
      gate_lo_q <= gate_lo_d;
      for (int n = 0; n < 3; n++) state_q[n] <= state_d[n];
    end
  end

  assign gate_hi        = gate_hi_q;
  assign gate_lo        = gate_lo_q;
  assign carrier        = carrier_q;
  assign carrier_valley = valley_q;
  assign fault_latched  = fault_q;

endmodule

// File: tb/tb_spwm_deadtime_generator.sv
// Scoreboarded random bench: a cycle-history reference model predicts every
// output after each clock edge; a negedge monitor pops and compares.
module tb_spwm_deadtime_generator;
  localparam int CM = 40;
  localparam int DT = 6;

  logic        clk = 1'b0;
  logic        rst, enable, fault_in, fault_clear;
  logic [11:0] modulated_wave_1, modulated_wave_2, modulated_wave_3;
  logic [2:0]  gate_hi, gate_lo;
  logic [11:0] carrier;
  logic        carrier_valley, fault_latched;

  always #5 clk = ~clk;

  spwm_deadtime_generator #(.CARRIER_MAX(CM), .DEADTIME(DT)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .modulated_wave_1(modulated_wave_1), .modulated_wave_2(modulated_wave_2),
    .modulated_wave_3(modulated_wave_3), .fault_in(fault_in),
    .fault_clear(fault_clear), .gate_hi(gate_hi), .gate_lo(gate_lo),
    .carrier(carrier), .carrier_valley(carrier_valley),
    .fault_latched(fault_latched)
  );

  typedef struct {
    logic [2:0]  hi, lo;
    logic [11:0] car;
    logic        valley, fault;
  } exp_t;

  exp_t        sb[$];
  logic        hist_f[$];
  logic [2:0]  hist_c[$];
  int          rf[3];
  int          m_phase;
  int          m_sh[3];
  logic [2:0]  m_cmp, m_hi, m_lo;
  logic        m_fault;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  // Triangle value as a pure function of cycles spent running.
  function automatic int car_of(input int p);
    int q;
    q = p % (2 * CM);
    return (q <= CM) ? q : 2 * CM - q;
  endfunction

  function automatic int rnd_ref();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 4095));
    return int'($urandom_range(0, CM + 2));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Gates from demand history: a side turns on once demand has held it for
  // DT+1 unforced cycles (DT straight after a forced idle for the low side).
  task automatic model_step();
    logic       forced, valley, run, prevf;
    logic [2:0] nhi, nlo, ncmp;
    int         k, idx, car;
    forced = rst | ~enable | m_fault | fault_in;
    hist_f.push_back(forced);
    hist_c.push_back(m_cmp);
    if (hist_f.size() > DT + 3) begin
      void'(hist_f.pop_front());
      void'(hist_c.pop_front());
    end
    nhi = '0;
    nlo = '0;
    for (int n = 0; n < 3; n++) begin
      k = 0;
      idx = hist_f.size() - 1;
      while (idx >= 0 && k <= DT && !hist_f[idx] && hist_c[idx][n] == m_cmp[n]) begin
        k++;
        idx--;
      end
      prevf = (idx < 0) ? 1'b1 : hist_f[idx];
      if (!forced) begin
        if (m_cmp[n]) nhi[n] = m_hi[n] || (k >= DT + 1);
        else          nlo[n] = m_lo[n] || (k >= DT + 1) || (k >= DT && prevf);
      end
    end
    m_hi = nhi;
    m_lo = nlo;
    if (rst) begin
      m_phase = 0;
      m_fault = 1'b0;
      m_cmp   = '0;
      valley  = 1'b0;
      for (int n = 0; n < 3; n++) m_sh[n] = 0;
    end else begin
      run    = enable & ~m_fault;
      car    = car_of(m_phase);
      valley = run && (car == 0);
      for (int n = 0; n < 3; n++) ncmp[n] = (m_sh[n] > car);
      m_cmp = ncmp;
      if (valley) for (int n = 0; n < 3; n++) m_sh[n] = (rf[n] > CM) ? CM : rf[n];
      m_phase = run ? (m_phase + 1) % (2 * CM) : 0;
      m_fault = fault_in ? 1'b1 : (fault_clear ? 1'b0 : m_fault);
    end
    sb.push_back('{hi: m_hi, lo: m_lo, car: 12'(car_of(m_phase)),
                   valley: valley, fault: m_fault});
  endtask

  task automatic drive(input logic r, input logic e, input logic fi, input logic fc);
    rst = r; enable = e; fault_in = fi; fault_clear = fc;
    modulated_wave_1 = 12'(rf[0]);
    modulated_wave_2 = 12'(rf[1]);
    modulated_wave_3 = 12'(rf[2]);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_refs(input int a, input int b, input int c);
    rf[0] = a; rf[1] = b; rf[2] = c;
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("carrier", int'(carrier), int'(e.car));
      chk("valley", int'(carrier_valley), int'(e.valley));
      chk("fault_latched", int'(fault_latched), int'(e.fault));
      chk("gate_hi", int'(gate_hi), int'(e.hi));
      chk("gate_lo", int'(gate_lo), int'(e.lo));
      chk("overlap", int'(gate_hi & gate_lo), 0);
    end
  end

  initial begin
    m_phase = 0; m_fault = 1'b0; m_cmp = '0; m_hi = '0; m_lo = '0;
    for (int n = 0; n < 3; n++) m_sh[n] = 0;
    set_refs(0, 0, 0);
    repeat (3) drive(1, 0, 0, 0);

    set_refs(CM / 2, 0, CM);
    repeat (200) drive(0, 1, 0, 0);
    set_refs(1, 1, CM - 1);
    repeat (170) drive(0, 1, 0, 0);

    // Mid-period reference change only takes effect at the next valley.
    set_refs(10, 10, 10);
    repeat (95) drive(0, 1, 0, 0);
    set_refs(30, 30, 30);
    repeat (120) drive(0, 1, 0, 0);

    repeat (10) begin
      set_refs(rnd_ref(), rnd_ref(), rnd_ref());
      repeat ($urandom_range(20, 120)) drive(0, 1, 0, 0);
    end

    set_refs(30, 30, 30);
    repeat (60) drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    repeat (5) drive(0, 1, 0, 0);
    drive(0, 1, 1, 1);
    repeat (5) drive(0, 1, 0, 0);
    drive(0, 1, 0, 1);
    repeat (150) drive(0, 1, 0, 0);

    repeat (10) drive(0, 0, 0, 0);
    repeat (100) drive(0, 1, 0, 0);
    repeat (33) drive(0, 1, 0, 0);
    drive(1, 1, 1, 1);
    repeat (100) drive(0, 1, 0, 0);

    repeat (6000) begin
      if ($urandom_range(0, 49) == 0) set_refs(rnd_ref(), rnd_ref(), rnd_ref());
      drive($urandom_range(0, 999) == 0, $urandom_range(0, 99) != 0,
            $urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
